keypad_scan_4x4: RTL

// - Scans a 4x4 active-low matrix keypad, synchronises and debounces the row

---
 rtl/keypad_scan_4x4_if.sv | 31 +++
 rtl/keypad_scan_4x4.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_4x4_if.sv
// Keypad scanner signal bundle: matrix lines plus the decoded key outputs.
// Latency: none, wiring only.
// Backpressure: none; key_valid is a fire-and-forget strobe.
interface keypad_scan_4x4_if;
  logic [3:0]  row_in;     // active-low rows from the keypad, asynchronous
  logic [3:0]  col_out;    // active-low column drive, exactly one bit low
  logic [15:0] onehot;     // debounced key, bit row*4+col, zero when idle
  logic [3:0]  key_code;   // index of the last accepted key
  logic        key_valid;  // single-cycle strobe on press acceptance
  logic        key_down;   // high while a key is held

  // Scanner side: reads rows, drives columns and the decoded key.
  modport master (
    input  row_in,
    output col_out,
    output onehot,
    output key_code,
    output key_valid,
    output key_down
  );

  // Keypad / consumer side.
  modport slave (
    output row_in,
    input  col_out,
    input  onehot,
    input  key_code,
    input  key_valid,
    input  key_down
  );
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 active-low keypad scanner with row sync, debounce and one-hot key output.
// Latency: press accepted DEBOUNCE_TICKS scan ticks after detection, plus up to 3 ticks scan wait.
// Backpressure: none; key_valid pulses once per accepted press. Optional: KEYPAD_GHOST_REJECT_EN.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_scan_4x4_if.master  kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W:0]   DB_LIM   = (CNT_W + 1)'(DEBOUNCE_TICKS);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div;
  logic             tick;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             cnt_done;
  logic [1:0]       col_idx;
  logic [3:0]       latched;

  logic [3:0]       row_low;
  logic             any_low;
  logic             multi_low;
  logic             pat_idle;
  logic [1:0]       sel_row;
  logic [3:0]       key_idx;

  logic [3:0]       col_drv;
  logic [15:0]      onehot_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_down_q;

  // Two-flop synchroniser; rows idle high so reset to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row_in;
      row_sync <= row_meta;
    end
  end

  // Scan-rate divider: one tick every SCAN_DIV clocks, leaving time for
  // a column change to settle and pass through the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == DIV_LAST);

  // Classify the synced row pattern; a ghost-reject build treats any
  // multi-row pattern exactly like an idle keypad.
  always_comb begin
    row_low   = ~row_sync;
    any_low   = |row_low;
    multi_low = |(row_low & (row_low - 4'd1));
`ifdef KEYPAD_GHOST_REJECT_EN
    pat_idle  = !any_low || multi_low;
`else
    pat_idle  = !any_low;
`endif
  end

  // Lowest-index low row of the latched pattern selects the key row.
  always_comb begin
    sel_row = 2'd3;
    if (!latched[0]) begin
      sel_row = 2'd0;
    end else if (!latched[1]) begin
      sel_row = 2'd1;
    end else if (!latched[2]) begin
      sel_row = 2'd2;
    end
    key_idx = {sel_row, col_idx};
  end

  // Debounce counter helpers shared by the press and release paths.
  always_comb begin
    cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    cnt_done = (cnt_inc >= DB_LIM);
  end

  // Scan / debounce / hold / release sequencer; acts only on tick cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SCAN;
      cnt         <= '0;
      col_idx     <= 2'd0;
      latched     <= 4'hF;
      onehot_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (pat_idle) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              latched <= row_sync;
              cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
              state   <= ST_DEBOUNCE;
            end
          end

          ST_DEBOUNCE: begin
            if (!pat_idle && (row_sync == latched)) begin
              if (cnt_done) begin
                // Stable for long enough: publish the key this cycle.
                state       <= ST_PRESSED;
                cnt         <= '0;
                onehot_q    <= 16'd1 << key_idx;
                key_code_q  <= key_idx;
                key_down_q  <= 1'b1;
                key_valid_q <= 1'b1;
              end else begin
                cnt <= cnt_inc[CNT_W-1:0];
              end
            end else begin
              // Bounce or change of pattern: give up and keep scanning.
              state   <= ST_SCAN;
              cnt     <= '0;
              col_idx <= col_idx + 2'd1;
            end
          end

          ST_PRESSED: begin
            // Other keys pressed meanwhile are ignored until full release.
            if (pat_idle) begin
              cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
              state <= ST_RELEASE;
            end
          end

          ST_RELEASE: begin
            if (pat_idle) begin
              if (cnt_done) begin
                // key_code deliberately keeps the last accepted key.
                state      <= ST_SCAN;
                cnt        <= '0;
                onehot_q   <= '0;
                key_down_q <= 1'b0;
                col_idx    <= col_idx + 2'd1;
              end else begin
                cnt <= cnt_inc[CNT_W-1:0];
              end
            end else begin
              // Release glitch: resume holding, no fresh strobe.
              state <= ST_PRESSED;
              cnt   <= '0;
            end
          end

          default: begin
            state <= ST_SCAN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Column drive: one active-low bit for the current column index.
  always_comb begin
    col_drv          = 4'b1111;
    col_drv[col_idx] = 1'b0;
  end

  assign kp.col_out   = col_drv;
  assign kp.onehot    = onehot_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;

endmodule
